// File: rtl/lsu_rmw.sv
// lsu_rmw: load/store unit in front of a word-organised data RAM.
//
// Takes one CPU memory request at a time, runs it on the RAM bus and returns
// a single-cycle completion pulse. Sub-word loads are sign- or zero-extended.
// The RAM only commits full words, so byte/half stores are done as a
// read-modify-write: read the containing word, merge the new lane(s), then
// write the whole word back. Misaligned or illegal-size requests complete
// with resp_err=1 and never touch the bus.
//
// Handshake: a request transfers on the posedge where req_valid && req_ready.
// req_ready is high only in IDLE; the CPU keeps req_valid and all req_*
// fields stable until that edge. resp_valid is a one-cycle pulse with no
// back-pressure; resp_err and resp_rdata are meaningful while it is high,
// and resp_rdata keeps its value until the next response.
//
// Ports:
//   clk, rst         clock, asynchronous active-high reset
//   req_valid/ready  request handshake
//   req_write        1 = store, 0 = load
//   req_addr         byte address
//   req_size         01 byte, 10 half, 11 word, 00 illegal
//   req_unsigned     loads zero-extend when 1, sign-extend when 0
//   req_wdata        right-aligned store data
//   resp_valid       completion pulse
//   resp_err         misaligned / illegal size
//   resp_rdata       extended load data, 0 for stores and errors
//   mem_addr/size/rw RAM control; mem_rw=1 is a write
//   mem_data         bidirectional RAM data, driven here only while mem_rw=1
module lsu_rmw #(
  parameter logic [31:0] IDLE_ADDR = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [31:0] req_addr,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic        resp_err,
  output logic [31:0] resp_rdata,
  output logic [31:0] mem_addr,
  inout  wire  [31:0] mem_data,
  output logic [1:0]  mem_size,
  output logic        mem_rw
);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    LD_ISSUE  = 3'd1,
    LD_CAP    = 3'd2,
    RMW_ISSUE = 3'd3,
    RMW_MERGE = 3'd4,
    ST_WRITE  = 3'd5,
    RESP      = 3'd6
  } state_t;

  state_t      state, state_nxt;

  logic [31:0] addr_q;
  logic [1:0]  size_q;
  logic        unsigned_q;
  logic [31:0] wdata_q;    // store data, replaced by the merged word in RMW
  logic        err_q;
  logic [31:0] rdata_q;

  logic        accept;
  logic        req_bad;
  logic [31:0] load_ext;
  logic [31:0] merged;

  assign accept = req_valid && (state == IDLE);

  assign req_bad = (req_size == 2'b00) ||
                   ((req_size == 2'b10) && req_addr[0]) ||
                   ((req_size == 2'b11) && (req_addr[1:0] != 2'b00));

  // The RAM returns sub-word reads right-aligned for the addressed lane, so
  // only the low byte/half is looked at here; the upper bits are discarded.
  always_comb begin
    load_ext = mem_data;
    case (size_q)
      2'b01:   load_ext = {{24{mem_data[7]  & ~unsigned_q}}, mem_data[7:0]};
      2'b10:   load_ext = {{16{mem_data[15] & ~unsigned_q}}, mem_data[15:0]};
      default: load_ext = mem_data;
    endcase
  end

  // Lane merge for RMW: mem_data holds the full word read with size 11.
  always_comb begin
    merged = mem_data;
    if (size_q == 2'b01) begin
      case (addr_q[1:0])
        2'd0:    merged = {mem_data[31:8], wdata_q[7:0]};
        2'd1:    merged = {mem_data[31:16], wdata_q[7:0], mem_data[7:0]};
        2'd2:    merged = {mem_data[31:24], wdata_q[7:0], mem_data[15:0]};
        default: merged = {wdata_q[7:0], mem_data[23:0]};
      endcase
    end else begin
      merged = addr_q[1] ? {wdata_q[15:0], mem_data[15:0]}
                         : {mem_data[31:16], wdata_q[15:0]};
    end
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (req_valid) begin
          if (req_bad)                state_nxt = RESP;
          else if (!req_write)        state_nxt = LD_ISSUE;
          else if (req_size == 2'b11) state_nxt = ST_WRITE;
          else                        state_nxt = RMW_ISSUE;
        end
      end
      LD_ISSUE:  state_nxt = LD_CAP;
      LD_CAP:    state_nxt = RESP;
      RMW_ISSUE: state_nxt = RMW_MERGE;
      RMW_MERGE: state_nxt = ST_WRITE;
      ST_WRITE:  state_nxt = RESP;
      RESP:      state_nxt = IDLE;
      default:   state_nxt = IDLE;
    endcase
  end

  // Bus and handshake outputs are decoded purely from state, so the async
  // reset of the state register returns them to idle values immediately and
  // mem_rw cannot stay high into reset.
  always_comb begin
    req_ready  = 1'b0;
    resp_valid = 1'b0;
    resp_err   = 1'b0;
    mem_addr   = IDLE_ADDR;
    mem_size   = 2'b11;
    mem_rw     = 1'b0;
    case (state)
      IDLE: req_ready = 1'b1;
      LD_ISSUE, LD_CAP: begin
        mem_addr = addr_q;
        mem_size = size_q;
      end
      RMW_ISSUE, RMW_MERGE: begin
        mem_addr = {addr_q[31:2], 2'b00};
      end
      ST_WRITE: begin
        mem_addr = {addr_q[31:2], 2'b00};
        mem_rw   = 1'b1;
      end
      RESP: begin
        resp_valid = 1'b1;
        resp_err   = err_q;
      end
      default: ;
    endcase
  end

  assign resp_rdata = rdata_q;
  assign mem_data   = mem_rw ? wdata_q : 32'hzzzz_zzzz;

  // Request capture, load data and RMW merge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      addr_q     <= '0;
      size_q     <= 2'b11;
      unsigned_q <= 1'b0;
      wdata_q    <= '0;
      err_q      <= 1'b0;
      rdata_q    <= '0;
    end else begin
      if (accept) begin
        addr_q     <= req_addr;
        size_q     <= req_size;
        unsigned_q <= req_unsigned;
        wdata_q    <= req_wdata;
        err_q      <= req_bad;
        if (req_bad) rdata_q <= '0;
      end
      case (state)
        LD_CAP:    rdata_q <= load_ext;
        RMW_MERGE: wdata_q <= merged;
        ST_WRITE:  rdata_q <= '0;
        default:   ;
      endcase
    end
  end

endmodule

// File: doc/lsu_rmw.md
Name: lsu_rmw

Overview:
- Load/store unit that sits directly upstream of the word-organised data RAM and drives its addr/data/size/rw bus.
- Accepts one CPU memory request at a time over a valid/ready handshake, sign- or zero-extends sub-word loads, and reports misaligned accesses.
- The RAM only commits full-word writes, so byte and halfword stores are performed as read-modify-write sequences.

Parameters:
- IDLE_ADDR, 32'h0000_0000, value driven on mem_addr when no access is in progress; must lie outside every bus target's window.

Ports:
- clk  input  1  system clock, all state on posedge.
- rst  input  1  asynchronous, active-high reset.
- req_valid  input  1  CPU request present.
- req_ready  output  1  high only in IDLE; request accepted on posedge with req_valid && req_ready.
- req_write  input  1  1 = store, 0 = load.
- req_addr  input  32  byte address.
- req_size  input  2  01 byte, 10 half, 11 word; 00 illegal.
- req_unsigned  input  1  load zero-extends when 1, sign-extends when 0.
- req_wdata  input  32  store data, right-aligned (byte in [7:0], half in [15:0]).
- resp_valid  output  1  one-cycle completion pulse.
- resp_err  output  1  valid with resp_valid; 1 = misaligned or illegal size.
- resp_rdata  output  32  extended load data; 0 for stores and errors.
- mem_addr  output  32  RAM address.
- mem_data  inout  32  driven only while mem_rw=1, otherwise high-Z.
- mem_size  output  2  RAM size code.
- mem_rw  output  1  1 = write.

Behaviour:
- Reset values (asynchronous, take effect immediately):
  - state=IDLE; req_ready=1; resp_valid=0; resp_err=0; resp_rdata=0.
  - mem_rw=0; mem_addr=IDLE_ADDR; mem_size=2'b11; mem_data=Z.
- Accept: all req_* fields are latched on the accept edge. req_valid outside IDLE is ignored; the CPU holds it until accepted.
- Misaligned or illegal requests:
  - Conditions: size 00; half with addr[0]=1; word with addr[1:0]!=0.
  - Action: IDLE→RESP with resp_err=1 and resp_rdata=0. No bus activity.
- RAM read timing: the RAM registers read data on the posedge where addr is valid and rw=0. Data is sampled on the following posedge, with addr and rw=0 still held.
- States and outputs:
  - IDLE: bus at reset values.
  - LD_ISSUE: mem_addr=latched addr, mem_size=latched size, mem_rw=0. Next state LD_CAP.
  - LD_CAP: same bus values. On the posedge, capture mem_data and extend bit 7 (byte) or bit 15 (half) into resp_rdata per req_unsigned; word passes through. Next state RESP.
  - RMW_ISSUE: mem_addr={addr[31:2],2'b00}, mem_size=11, mem_rw=0. Next state RMW_MERGE.
  - RMW_MERGE: same bus values. Capture the word and replace lane addr[1:0] (byte) or half addr[1] (half) with req_wdata. Next state ST_WRITE.
  - ST_WRITE: mem_addr word-aligned, mem_size=11, mem_rw=1, mem_data = merged word (sub-word) or req_wdata (word). Exactly one cycle. Next state RESP.
  - RESP: resp_valid=1 for exactly one cycle, bus idle. Next state IDLE.
- Word stores go IDLE→ST_WRITE. Loads go IDLE→LD_ISSUE. Sub-word stores go IDLE→RMW_ISSUE.
- Latency (cycles from accept edge to the resp_valid cycle; throughput one request per latency+1 cycles):
  - error: 1
  - word store: 2
  - load: 3
  - sub-word store: 4
- resp_rdata holds its value until the next RESP.
- Reset mid-operation: mem_rw drops asynchronously, so no partial write is committed after reset rises. The pending request is dropped with no response.
- Address wrap: no range check. Out-of-window addresses are passed through, and loads return whatever the bus presents.

Test Plan:
- Word store then load:
  - Stimulus: store 0xDEADBEEF to 0x2000_0010, then load word from 0x2000_0010.
  - Required: mem_rw=1 for exactly one cycle, resp_valid at +2; load resp_rdata=0xDEADBEEF at +3, resp_err=0.
- Signed and unsigned byte load:
  - Stimulus: word 0x80FF7F01 at 0x2000_0020; load byte at 0x2000_0022 signed, then unsigned.
  - Required: signed 0xFFFFFFFF, unsigned 0x000000FF; signed half at 0x2000_0022 returns 0xFFFF80FF.
- Byte RMW:
  - Stimulus: word 0x11223344 at 0x2000_0030; store byte 0xAA at 0x2000_0031.
  - Required: single write of 0x1122AA44 to 0x2000_0030, resp_valid at +4; subsequent word load returns 0x1122AA44.
- Misaligned:
  - Stimulus: half load at 0x2000_0003 and word store at 0x2000_0002.
  - Required: each resp_valid=1 with resp_err=1 at +1, resp_rdata=0; mem_rw never 1 and mem_addr stays IDLE_ADDR.
- Back-pressure:
  - Stimulus: req_valid held continuously during a sub-word store.
  - Required: req_ready=0 for 4 cycles, second request accepted only in the cycle after RESP.
- Reset mid-RMW:
  - Stimulus: assert rst between posedges while in RMW_MERGE.
  - Required: outputs reach reset values immediately, no write to the target word (it still reads 0x11223344), no resp_valid.
